// File: rtl/cb_config_loader_if.sv
// cb_config_loader_if
// Configuration word stream from a configuration source into cb_config_loader.
// Signals:
//   start      load start / restart pulse (source -> loader)
//   cfg_data   IN_W-bit configuration word, LSB-first within the bitstream
//   cfg_valid  cfg_data is valid (source -> loader)
//   cfg_ready  loader accepts a word this cycle (loader -> source)
// Modports: master = configuration source, slave = loader.
interface cb_config_loader_if #(
   parameter int IN_W = 8
) ();
   logic            start;
   logic [IN_W-1:0] cfg_data;
   logic            cfg_valid;
   logic            cfg_ready;

   modport master (output start, output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input start, input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cb_config_loader.sv
// cb_config_loader
// Assembles a connection-block configuration from a stream of IN_W-bit words
// in a shadow register and commits it to c with a one-cycle cset strobe, so
// the connection block never sees a partially loaded configuration.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (c cleared, cset held high)
//   cfg       configuration word stream (slave side: start/data/valid in, ready out)
//   c         committed configuration, registered
//   cset      configuration-latch strobe to the connection block
//   busy      high while loading or committing
//   done      high once a configuration has been committed
//   word_cnt  words accepted in the current load
module cb_config_loader #(
   parameter int W       = 16,
   parameter int WW      = 4,
   parameter int DATAIN  = 4,
   parameter int DATAOUT = 3,
   parameter int IN_W    = 8,
   parameter int CFG_W   = $clog2(2*W/WW)*DATAIN*WW + $clog2(DATAOUT+1)*W*2,
   parameter int NWORDS  = (CFG_W+IN_W-1)/IN_W
) (
   input  logic                         clk,
   input  logic                         rst,
   cb_config_loader_if.slave            cfg,
   output logic [CFG_W-1:0]             c,
   output logic                         cset,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NWORDS+1)-1:0]  word_cnt
);
   localparam int CNT_W = $clog2(NWORDS+1);
   localparam int SH_W  = NWORDS*IN_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [SH_W-1:0]  shadow_r;
   logic [SH_W-1:0]  merged_s;
   logic [CNT_W-1:0] word_cnt_r;
   logic [CFG_W-1:0] c_r;
   logic             cset_r;
   logic             busy_r;
   logic             done_r;
   logic             ready_r;
   logic             restart_s;
   logic             accept_s;
   logic             last_s;

   // start is honoured everywhere except COMMIT, which always runs to completion;
   // a word presented together with start is not consumed.
   assign restart_s = cfg.start && (state_r != COMMIT);
   assign accept_s  = (state_r == LOAD) && cfg.cfg_valid && !cfg.start;
   assign last_s    = accept_s && (word_cnt_r == CNT_W'(NWORDS-1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cfg.start) next_state_s = LOAD;
            else           next_state_s = IDLE;
         end
         LOAD: begin
            if (cfg.start)   next_state_s = LOAD;
            else if (last_s) next_state_s = COMMIT;
            else             next_state_s = LOAD;
         end
         COMMIT: begin
            next_state_s = DONE;
         end
         DONE: begin
            if (cfg.start) next_state_s = LOAD;
            else           next_state_s = DONE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Shadow register with the current word merged into slot word_cnt; also the
   // value committed to c on the final word, so c updates on the accepting edge.
   always_comb begin
      merged_s = shadow_r;
      for (int k = 0; k < NWORDS; k++) begin
         if (word_cnt_r == CNT_W'(k)) begin
            merged_s[k*IN_W +: IN_W] = cfg.cfg_data;
         end else begin
            merged_s[k*IN_W +: IN_W] = shadow_r[k*IN_W +: IN_W];
         end
      end
   end

   // Shadow register, word counter and committed configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_r   <= {SH_W{1'b0}};
         word_cnt_r <= {CNT_W{1'b0}};
         c_r        <= {CFG_W{1'b0}};
      end else if (restart_s) begin
         // c deliberately untouched: the previous configuration stays live.
         shadow_r   <= {SH_W{1'b0}};
         word_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         shadow_r   <= merged_s;
         word_cnt_r <= word_cnt_r + CNT_W'(1);
         if (last_s) begin
            // Bits beyond CFG_W in the final word are dropped here.
            c_r <= merged_s[CFG_W-1:0];
         end else begin
            c_r <= c_r;
         end
      end else begin
         shadow_r   <= shadow_r;
         word_cnt_r <= word_cnt_r;
         c_r        <= c_r;
      end
   end

   // Status outputs registered from the next state; cset also held high in
   // reset so the connection block latches the all-zero default.
   always_ff @(posedge clk) begin
      if (rst) begin
         cset_r  <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         cset_r  <= (next_state_s == COMMIT);
         busy_r  <= (next_state_s == LOAD) || (next_state_s == COMMIT);
         done_r  <= (next_state_s == DONE);
         ready_r <= (next_state_s == LOAD);
      end
   end

   assign c             = c_r;
   assign cset          = cset_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign word_cnt      = word_cnt_r;
   assign cfg.cfg_ready = ready_r;
endmodule

// File: tb/tb_cb_config_loader.sv
// tb_cb_config_loader
// Bench for cb_config_loader: default-parameter instance checked every cycle
// against a behavioural model (accepted-word list, committed value, phase
// flags), plus a CFG_W=20 instance for the partial-final-word case.
module tb_cb_config_loader;
   localparam int CFG_W = 112;
   localparam int NW    = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   cb_config_loader_if #(.IN_W(8)) bus ();
   cb_config_loader_if #(.IN_W(8)) bus20 ();

   logic [CFG_W-1:0] c;
   logic             cset, busy, done;
   logic [3:0]       word_cnt;

   logic [19:0]      c20;
   logic             cset20, busy20, done20;
   logic [1:0]       word_cnt20;

   cb_config_loader dut (
      .clk(clk), .rst(rst), .cfg(bus),
      .c(c), .cset(cset), .busy(busy), .done(done), .word_cnt(word_cnt)
   );

   cb_config_loader #(.CFG_W(20)) dut20 (
      .clk(clk), .rst(rst), .cfg(bus20),
      .c(c20), .cset(cset20), .busy(busy20), .done(done20), .word_cnt(word_cnt20)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [7:0]   acc_q[$];
   int           nacc;
   bit           loading, pend, fin, cset_exp;
   logic [127:0] c_exp;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the rules of one clock edge to the model.
   task automatic model_edge(input bit r, input bit s, input bit v, input logic [7:0] d);
      if (r) begin
         loading = 1'b0; pend = 1'b0; fin = 1'b0; nacc = 0;
         acc_q.delete();
         c_exp = 128'd0;
      end else if (pend) begin
         pend = 1'b0; fin = 1'b1;
      end else if (s) begin
         loading = 1'b1; fin = 1'b0; nacc = 0;
         acc_q.delete();
      end else if (loading && v) begin
         acc_q.push_back(d);
         nacc++;
         if (nacc == NW) begin
            loading = 1'b0; pend = 1'b1;
            c_exp = 128'd0;
            foreach (acc_q[k]) c_exp[k*8 +: 8] = acc_q[k];
         end
      end
      cset_exp = r || pend;
   endtask

   task automatic check_all();
      chk("c",         c,             c_exp);
      chk("cset",      cset,          cset_exp);
      chk("cfg_ready", bus.cfg_ready, loading);
      chk("busy",      busy,          loading || pend);
      chk("done",      done,          fin);
      chk("word_cnt",  word_cnt,      nacc);
   endtask

   task automatic cycle(input bit r, input bit s, input bit v, input logic [7:0] d);
      rst = r; bus.start = s; bus.cfg_valid = v; bus.cfg_data = d;
      @(posedge clk);
      model_edge(r, s, v, d);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [127:0] k_exp;
      rst = 1'b1;
      bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = 8'h00;
      bus20.start = 1'b0; bus20.cfg_valid = 1'b0; bus20.cfg_data = 8'h00;

      // Reset default: cset high, c zero for both reset cycles
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_cset", cset, 1'b1);
      chk("rst_c", c, 128'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("rel_cset", cset, 1'b0);
      chk("rel_done", done, 1'b0);

      // Full load without stalls
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 1; k <= NW; k++) cycle(1'b0, 1'b0, 1'b1, 8'(k));
      k_exp = 128'd0;
      for (int k = 0; k < NW; k++) k_exp[k*8 +: 8] = 8'(k + 1);
      chk("full_c", c, k_exp);
      chk("full_cset", cset, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("full_done", done, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Stalled load: valid every other cycle, data changes while not valid
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 1; k <= NW; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'hEE);
         cycle(1'b0, 1'b0, 1'b1, 8'(k));
      end
      chk("stall_c", c, k_exp);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Partial final word on the CFG_W=20 instance
      bus20.start = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      bus20.start = 1'b0; bus20.cfg_valid = 1'b1; bus20.cfg_data = 8'hFF;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("p20_c_hold", c20, 128'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("p20_c", c20, 128'hFFFFF);
      chk("p20_cset", cset20, 1'b1);
      chk("p20_cnt", word_cnt20, 2'd3);
      bus20.cfg_valid = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("p20_done", done20, 1'b1);
      chk("p20_c_keep", c20, 128'hFFFFF);

      // Abort: commit AA, partial 55 load, restart, commit 33
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < NW; k++) cycle(1'b0, 1'b0, 1'b1, 8'hAA);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 8'h55);
      cycle(1'b0, 1'b1, 1'b1, 8'h55);
      chk("abort_cnt", word_cnt, 4'd0);
      chk("abort_c", c, {14{8'hAA}});
      for (int k = 0; k < NW; k++) cycle(1'b0, 1'b0, 1'b1, 8'h33);
      chk("abort_new_c", c, {14{8'h33}});
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Reset mid-load, then words presented without start are ignored
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 1'b1, 8'h5A);
      cycle(1'b1, 1'b0, 1'b1, 8'h5A);
      chk("mid_rst_c", c, 128'd0);
      chk("mid_rst_cset", cset, 1'b1);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 8'h77);
      chk("mid_rst_cnt", word_cnt, 4'd0);
      chk("mid_rst_ready", bus.cfg_ready, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bit r, s, v;
         r = ($urandom_range(199, 0) == 0);
         s = ($urandom_range(49, 0) == 0);
         v = ($urandom_range(3, 0) != 0);
         cycle(r, s, v, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
